// File: rtl/vga_scan_ctrl.sv
// VGA timing generator: pixel clock-enable, position counters, registered syncs,
// and a per-line req/ack render request with a sticky underrun flag.
module vga_scan_ctrl #(
    parameter int PIX_DIV   = 2,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0
) (
    input  logic        clk48,
    input  logic        rst,
    output logic        pix_ce,
    output logic [10:0] hpos,
    output logic [9:0]  vpos,
    output logic        active,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic        line_req,
    output logic [9:0]  line_num,
    input  logic        line_ack,
    output logic        underrun,
    input  logic        underrun_clr
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic        HS_ON    = (HSYNC_POL != 0);
    localparam logic        VS_ON    = (VSYNC_POL != 0);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [DIV_W-1:0] r_div;
    logic             r_pix_ce;
    logic [10:0]      r_hpos;
    logic [9:0]       r_vpos;
    logic             r_active;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_frame_start;
    logic [0:0]       r_state;
    logic [9:0]       r_line_num;
    logic             r_underrun;

    logic             w_h_last;
    logic             w_v_last;
    logic [10:0]      w_hpos_next;
    logic [9:0]       w_vpos_next;
    logic [9:0]       w_line_next;
    logic             w_launch;
    logic             w_deadline;
    logic             w_miss;
    logic             w_hs_on;
    logic             w_vs_on;

    always_ff @(posedge clk48) begin
        if (rst) begin
            r_div    <= '0;
            r_pix_ce <= 1'b0;
        end else begin
            r_pix_ce <= (r_div == DIV_LAST);
            r_div    <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    // Everything below is computed from the position about to be loaded, so the
    // decoded outputs land in the same cycle as the counters they describe.
    assign w_h_last    = (r_hpos == H_LAST);
    assign w_v_last    = (r_vpos == V_LAST);
    assign w_hpos_next = w_h_last ? 11'd0 : r_hpos + 11'd1;
    assign w_vpos_next = w_h_last ? (w_v_last ? 10'd0 : r_vpos + 10'd1) : r_vpos;
    assign w_line_next = w_v_last ? 10'd0 : r_vpos + 10'd1;
    assign w_launch    = r_pix_ce && (w_hpos_next == H_ACT_C);
    assign w_deadline  = r_pix_ce && (w_hpos_next == 11'd0);
    assign w_miss      = (r_state == S_REQ) && w_deadline && !line_ack;
    assign w_hs_on     = (w_hpos_next >= HS_START) && (w_hpos_next < HS_END);
    assign w_vs_on     = (w_vpos_next >= VS_START) && (w_vpos_next < VS_END);

    always_ff @(posedge clk48) begin
        if (rst) begin
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_active      <= 1'b0;
            r_hsync       <= ~HS_ON;
            r_vsync       <= ~VS_ON;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= r_pix_ce && w_h_last && w_v_last;
            if (r_pix_ce) begin
                r_hpos   <= w_hpos_next;
                r_vpos   <= w_vpos_next;
                r_active <= (w_hpos_next < H_ACT_C) && (w_vpos_next < V_ACT_C);
                r_hsync  <= w_hs_on ? HS_ON : ~HS_ON;
                r_vsync  <= w_vs_on ? VS_ON : ~VS_ON;
            end
        end
    end

    // An ack arriving on the deadline edge still completes the request cleanly.
    always_ff @(posedge clk48) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_line_num <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_launch && (w_line_next < V_ACT_C)) begin
                    r_state    <= S_REQ;
                    r_line_num <= w_line_next;
                end
            end else begin
                if (line_ack || w_deadline) begin
                    r_state <= S_IDLE;
                end
            end
            if (w_miss) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign pix_ce      = r_pix_ce;
    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign active      = r_active;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;
    assign line_req    = (r_state == S_REQ);
    assign line_num    = r_line_num;
    assign underrun    = r_underrun;

endmodule
